// File: rtl/mux9_rr_arbiter.sv
// Round-robin arbiter for a shared 9:1 mux; drives one-hot grant and mux sel.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles in GRANT.
module mux9_rr_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [8:0]       req,
   input  logic             done,
   output logic [8:0]       grant,
   output logic [3:0]       sel,
   output logic             active,
   output logic [CNT_W-1:0] hold_cnt,
   output logic             timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_REL   = 2'd2;

   logic [1:0] state;
   logic [3:0] ptr;
   logic [3:0] win;
   logic       found;
   logic [4:0] idx;
   logic       rel_norm;
   logic       tmo_hit;

   always_ff @(posedge clk) begin
      assert (MAX_HOLD >= 2 && MAX_HOLD <= 255 &&
              MAX_HOLD < (2 ** CNT_W));
   end

   // Circular search from ptr; first set request wins.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < 9; k++) begin
         idx = 5'(ptr) + 5'(k);
         if (idx > 5'd8)
            idx = idx - 5'd9;
         if (!found && req[idx[3:0]]) begin
            found = 1'b1;
            win   = idx[3:0];
         end
      end
   end

   assign rel_norm = done | ~req[sel];

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   assign tmo_hit = (hold_cnt == HOLD_LAST);

   // Pulse only when the timeout alone forced the release.
   always_ff @(posedge clk) begin
      if (reset)
         timeout <= 1'b0;
      else
         timeout <= (state == S_GRANT) & tmo_hit & ~rel_norm;
   end
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         grant    <= '0;
         sel      <= '0;
         active   <= 1'b0;
         hold_cnt <= '0;
         ptr      <= '0;
      end else begin
         unique case (1'b1)
            (state == S_IDLE): begin
               if (found) begin
                  sel      <= win;
                  grant    <= 9'd1 << win;
                  active   <= 1'b1;
                  hold_cnt <= '0;
                  state    <= S_GRANT;
               end
            end
            (state == S_GRANT): begin
               if (rel_norm | tmo_hit) begin
                  grant    <= '0;
                  active   <= 1'b0;
                  hold_cnt <= '0;
                  ptr      <= (sel == 4'd8) ? 4'd0 : sel + 4'd1;
                  state    <= S_REL;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            (state == S_REL): begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Directed bench for mux9_rr_arbiter; build with ARB_TIMEOUT_EN for timeout.
module tb_mux9_rr_arbiter;

   localparam int MH = 4;

   logic       clk;
   logic       reset;
   logic [8:0] req;
   logic       done;
   logic [8:0] grant;
   logic [3:0] sel;
   logic       active;
   logic [7:0] hold_cnt;
   logic       timeout;

   int errs;
   int checks;

   mux9_rr_arbiter #(
      .MAX_HOLD(MH),
      .CNT_W   (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .sel     (sel),
      .active  (active),
      .hold_cnt(hold_cnt),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      errs   = 0;
      checks = 0;
      reset  = 1'b1;
      req    = '0;
      done   = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_grant", grant, 0);
      chk("rst_sel", sel, 0);
      chk("rst_active", active, 0);
      chk("rst_hold", hold_cnt, 0);
      chk("rst_tmo", timeout, 0);

      // single request, latency, hold count, done release
      req = 9'h010;
      cyc();
      chk("t1_grant", grant, 9'h010);
      chk("t1_sel", sel, 4);
      chk("t1_active", active, 1);
      chk("t1_hold0", hold_cnt, 0);
      cyc();
      chk("t1_hold1", hold_cnt, 1);
      cyc();
      chk("t1_hold2", hold_cnt, 2);
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk("t1_rel_grant", grant, 0);
      chk("t1_rel_active", active, 0);
      chk("t1_rel_hold", hold_cnt, 0);
      chk("t1_rel_sel", sel, 4);
      req = 9'h1FF;
      cyc();
      chk("t1_idle_grant", grant, 0);
      cyc();
      chk("t1_ptr5_sel", sel, 5);
      chk("t1_ptr5_grant", grant, 9'h020);

      // rotation with all requesters active
      req = 9'h1FF;
      done = 1'b0;
      do_reset();
      chk("rot_rst", grant, 0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("rot_sel", sel, i % 9);
         chk("rot_grant", grant, 9'd1 << (i % 9));
         done = 1'b1;
         cyc();
         done = 1'b0;
         chk("rot_rel", grant, 0);
         cyc();
         chk("rot_gap", grant, 0);
      end
      req = '0;

      // wrap from ptr=8
      req = 9'h080;
      do_reset();
      cyc();
      chk("wrap_g7", grant, 9'h080);
      done = 1'b1;
      req  = 9'h101;
      cyc();
      done = 1'b0;
      chk("wrap_rel0", grant, 0);
      cyc();
      chk("wrap_idle0", grant, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("wrap_sel", sel, (i == 1) ? 0 : 8);
         chk("wrap_grant", grant, (i == 1) ? 9'h001 : 9'h100);
         done = 1'b1;
         cyc();
         done = 1'b0;
         chk("wrap_rel", grant, 0);
         chk("wrap_sel_hold", sel, (i == 1) ? 0 : 8);
         cyc();
      end
      req = '0;

      // owner drops its request
      req = 9'h004;
      do_reset();
      cyc();
      chk("drop_g2", grant, 9'h004);
      req = 9'h009;
      cyc();
      chk("drop_rel", grant, 0);
      chk("drop_active", active, 0);
      cyc();
      chk("drop_idle", grant, 0);
      cyc();
      chk("drop_sel3", sel, 3);
      chk("drop_g3", grant, 9'h008);
      req = '0;

      // reset during a grant
      req = 9'h080;
      do_reset();
      cyc();
      chk("mrst_g7", grant, 9'h080);
      reset = 1'b1;
      req   = 9'h081;
      cyc();
      reset = 1'b0;
      chk("mrst_grant", grant, 0);
      chk("mrst_sel", sel, 0);
      chk("mrst_active", active, 0);
      chk("mrst_hold", hold_cnt, 0);
      cyc();
      chk("mrst_g0", grant, 9'h001);
      chk("mrst_sel0", sel, 0);
      req = '0;

      // forced release vs. indefinite hold
      req  = 9'h001;
      done = 1'b0;
      do_reset();
`ifdef ARB_TIMEOUT_EN
      for (int h = 0; h < MH; h++) begin
         cyc();
         chk("tmo_grant", grant, 9'h001);
         chk("tmo_hold", hold_cnt, h);
         chk("tmo_low", timeout, 0);
      end
      cyc();
      chk("tmo_pulse", timeout, 1);
      chk("tmo_rel", grant, 0);
      cyc();
      chk("tmo_end", timeout, 0);
      chk("tmo_idle", grant, 0);
      cyc();
      chk("tmo_regrant", grant, 9'h001);
      chk("tmo_regrant_hold", hold_cnt, 0);
`else
      for (int h = 0; h < 300; h++) begin
         cyc();
         chk("hold_cnt", hold_cnt, (h > 255) ? 255 : h);
         chk("hold_tmo", timeout, 0);
         if (h % 50 == 0)
            chk("hold_grant", grant, 9'h001);
      end
      chk("hold_grant_end", grant, 9'h001);
`endif
      req = '0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mux9_rr_arbiter.md
Name: mux9_rr_arbiter

Overview:
- Round-robin arbiter sharing one 9:1 multiplexed datapath between 9 requesters.
- Drives the mux select and a one-hot grant vector.
- Holds each grant until the owner signals done or drops its request.
- Sits directly in front of the 9-input multiplexer; its sel output feeds the mux select.

Parameters:
- MAX_HOLD, 16: max cycles a grant may be held when ARB_TIMEOUT_EN is defined; legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  9  request vector; bit i = requester i wants the mux.
- done  input  1  current owner finished; sampled only in GRANT.
- grant  output  9  registered one-hot grant; all zero when no owner.
- sel  output  4  registered mux select, 0..8; the mux lower 3 bits plus MSB cover index 8.
- active  output  1  high while a grant is held; equals the OR of grant.
- hold_cnt  output  CNT_W  cycles elapsed in current grant; 0 outside GRANT.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (synchronous; takes effect on the first rising clk edge with reset=1, overrides all activity including mid-grant):
  - state=IDLE, grant=0, sel=0, active=0, hold_cnt=0, timeout=0, ptr=0.
- ptr (0..8): index with highest priority at the next arbitration.
- Arbitration: search req circularly starting at ptr (ptr, ptr+1, ..., 8, 0, ..., ptr-1); the first set bit wins.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0: next edge loads winner w into sel, sets grant=1<<w and active=1, sets hold_cnt=0, goes to GRANT.
  - Latency: req seen in cycle n gives grant in cycle n+1.
  - If req == 0: stay; sel keeps its last value.
- GRANT:
  - hold_cnt increments each cycle and saturates at 2^CNT_W-1.
  - Release condition: done=1, OR req[sel]=0, OR (ARB_TIMEOUT_EN and hold_cnt==MAX_HOLD-1).
  - On release: next edge sets grant=0, active=0, hold_cnt=0, ptr=(sel==8)?0:sel+1, goes to RELEASE.
  - done and timeout in the same cycle: normal release; timeout is not pulsed.
- RELEASE:
  - One-cycle bus-turnaround gap, grant=0; unconditionally goes to IDLE.
  - Requests are ignored in RELEASE and are not latched.
  - Minimum spacing between consecutive grants: 2 idle cycles (RELEASE, IDLE).
- sel changes only on a new grant; it is stable throughout GRANT and RELEASE.
- Fairness: a requester holding req high continuously is granted within 8 other grants.
- done or req toggles outside GRANT have no effect.
- Requests are level-sensitive; no queuing. A request dropped before arbitration is lost.
- sel never takes values 9..15.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Grant is forcibly released when hold_cnt==MAX_HOLD-1 and no done or req drop occurs in that cycle, i.e. after exactly MAX_HOLD cycles in GRANT.
  - timeout pulses high for one cycle, coincident with the RELEASE state.
  - ptr advances as for a normal release.
- Not defined:
  - No forced release; a grant lasts until done or req drop.
  - timeout is tied to 0.
  - MAX_HOLD is unused.

Test Plan:
- Reset then req=9'h010 in cycle 0 -> cycle 1: grant=9'h010, sel=4, active=1; done in cycle 3 -> cycle 4: RELEASE with grant=0, ptr=5.
- Rotation: req=9'h1FF held, done pulsed each GRANT cycle -> sel sequence 0,1,2,...,8,0; exactly one grant every 3 cycles.
- Wrap: ptr=8 with req=9'h101 -> grant to 8, then 0, then 8; sel never exceeds 8.
- Owner drops req: grant to 2, req[2] falls with done=0 -> release next cycle, ptr=3, grant never re-asserted to 2 while req[2]=0.
- Timeout with MAX_HOLD=4 and macro defined, req=9'h001, done=0 -> grant held 4 cycles (hold_cnt 0..3), then timeout=1 for one cycle and grant=0; without the macro the grant is held indefinitely and timeout stays 0.
- Reset mid-grant: assert reset while grant=9'h080 -> next edge grant=0, sel=0, active=0, ptr=0; after reset deassert with req=9'h081 -> grant to 0 first.
